scale_mux_arbiter: RTL and testbench
====================================

// Module: scale_mux_arbiter
// PURPOSE
//  Shares one scale_mux datapath between two requesters (A, B) using valid/ready handshakes.
//  Round-robin FSM with burst limit chooses the owner and drives the mux select (o_sel_a).
//  The muxed word is captured into a single-entry output register toward one downstream consumer.
//  Sits in front of the VeriRISC operand/bus path wherever two sources contend for a scale_mux.
// PARAMETERS
//  WIDTH      8   data width of both requesters and of the output (matches scale_mux size)
//  MAX_BURST  4   max consecutive transfers granted to one requester while the other waits (>=1)
// PORTS
//  i_clk      in   1      single clock, all state updates on rising edge
//  i_rst      in   1      synchronous reset, active-high
//  i_a_valid  in   1      requester A has data
//  i_a_data   in   WIDTH  requester A data (mux input a)
//  o_a_ready  out  1      A transfer accepted this cycle when i_a_valid & o_a_ready
//  i_b_valid  in   1      requester B has data
//  i_b_data   in   WIDTH  requester B data (mux input b)
//  o_b_ready  out  1      B transfer accepted this cycle when i_b_valid & o_b_ready
//  o_sel_a    out  1      mux select: 1 = A owns datapath, 0 = B or idle
//  o_valid    out  1      output register holds a word
//  o_data     out  WIDTH  output word
//  i_ready    in   1      downstream consumes o_data when o_valid & i_ready
// BEHAVIOUR
//  Reset (i_rst=1 at edge): state=IDLE, last=B, burst_cnt=0, o_valid=0, o_data=0, o_sel_a=0;
//   o_a_ready=o_b_ready=0 while in IDLE. Reset wins over every other event; a pending o_valid is dropped.
//  States: IDLE, GNT_A, GNT_B. o_sel_a = (state==GNT_A), registered.
//  IDLE: both valid -> grant the opposite of last (A first after reset); one valid -> that one;
//   none -> stay. burst_cnt<=0 on every grant change.
//  Readiness: o_a_ready = (state==GNT_A) & (!o_valid | i_ready); o_b_ready is symmetric. No ready in IDLE.
//  Transfer X: o_data <= o_sel_a ? i_a_data : i_b_data; o_valid<=1; last<=X.
//   This is the scale_mux truth table: sel=1 selects a.
//  Consume with no new transfer: o_valid<=0. Consume and transfer in the same cycle: o_valid stays 1 with the new data.
//  GNT_X, evaluated at each edge in priority order:
//   1) transfer & burst_cnt==MAX_BURST-1 & other valid -> GNT_other, cnt=0
//   2) !x_valid -> GNT_other if other valid, else IDLE
//   3) transfer -> cnt=min(cnt+1, MAX_BURST-1); stay
//   4) else stay (backpressure)
//  Latency: valid in IDLE at cycle 0 -> grant/ready at cycle 1 -> o_valid at cycle 2. While granted, one word/cycle.
//  Requesters hold valid and data stable until accepted. The arbiter never drops or duplicates a word.
//  MAX_BURST=1: strict alternation whenever both valid.
// TESTING
//  T1 reset: i_rst=1 2 cycles, both valid=1 -> o_valid=0, o_data=00, o_sel_a=0, both ready=0
//  T2 single A: a_valid=1, a_data=ff, i_ready=1 -> cycle1 o_sel_a=1, o_a_ready=1; cycle2 o_valid=1, o_data=ff
//  T3 tie from IDLE: A=00, B=ff both valid one word each -> out 00 then ff, o_sel_a 1 then 0
//  T4 fairness MAX_BURST=4: both continuously valid, A=aa, B=55, i_ready=1 -> aa x4, 55 x4, aa x4
//  T5 backpressure: o_valid=1, i_ready=0 for 3 cycles -> o_data held, readies 0; release -> next word, no loss
//  T6 reset mid-burst after 2 A words -> next cycle o_valid=0, IDLE; both valid -> A granted first

Source files
------------

// File: rtl/scale_mux_arbiter.sv
// scale_mux_arbiter: round-robin, burst-limited owner of one scale_mux
// datapath, feeding a single-entry output register.
module scale_mux_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_a_valid,
  input  logic [WIDTH-1:0] i_a_data,
  output logic             o_a_ready,
  input  logic             i_b_valid,
  input  logic [WIDTH-1:0] i_b_data,
  output logic             o_b_ready,
  output logic             o_sel_a,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready
);

  localparam int CW =
    (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE,
    GNT_A,
    GNT_B
  } state_t;

  state_t           state_q;
  logic             last_a_q;
  logic [CW-1:0]    cnt_q;
  logic             sel_a_q;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  logic             can_load;
  logic             a_rdy;
  logic             b_rdy;
  logic             xfer_a;
  logic             xfer_b;
  logic             xfer;
  logic             at_limit;
  logic [CW-1:0]    cnt_inc;
  logic [WIDTH-1:0] mux_d;

  // The output slot can take a word when empty
  // or when its current word leaves this cycle.
  assign can_load = !valid_q || i_ready;
  assign a_rdy    = (state_q == GNT_A) && can_load;
  assign b_rdy    = (state_q == GNT_B) && can_load;
  assign xfer_a   = i_a_valid && a_rdy;
  assign xfer_b   = i_b_valid && b_rdy;
  assign xfer     = xfer_a || xfer_b;

  // Burst counter saturates at the limit; the
  // hand-over only happens when the other side waits.
  assign at_limit = (cnt_q == CNT_MAX);
  assign cnt_inc  = at_limit ? cnt_q
                             : cnt_q + 1'b1;

  // The shared scale_mux: sel=1 picks a.
  assign mux_d = sel_a_q ? i_a_data : i_b_data;

  // Ownership FSM: grant, burst count, last served.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      sel_a_q  <= 1'b0;
      cnt_q    <= '0;
      last_a_q <= 1'b0;
    end else begin
      if (xfer) begin
        last_a_q <= xfer_a;
      end
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (i_a_valid &&
              (!i_b_valid || !last_a_q)) begin
            state_q <= GNT_A;
            sel_a_q <= 1'b1;
          end else if (i_b_valid) begin
            state_q <= GNT_B;
            sel_a_q <= 1'b0;
          end
        end
        GNT_A: begin
          if (xfer_a && at_limit && i_b_valid) begin
            state_q <= GNT_B;
            sel_a_q <= 1'b0;
            cnt_q   <= '0;
          end else if (!i_a_valid) begin
            state_q <= i_b_valid ? GNT_B : IDLE;
            sel_a_q <= 1'b0;
            cnt_q   <= '0;
          end else if (xfer_a) begin
            cnt_q <= cnt_inc;
          end
        end
        GNT_B: begin
          if (xfer_b && at_limit && i_a_valid) begin
            state_q <= GNT_A;
            sel_a_q <= 1'b1;
            cnt_q   <= '0;
          end else if (!i_b_valid) begin
            state_q <= i_a_valid ? GNT_A : IDLE;
            sel_a_q <= i_a_valid;
            cnt_q   <= '0;
          end else if (xfer_b) begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= IDLE;
          sel_a_q <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Single-entry output register toward the consumer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (xfer) begin
      valid_q <= 1'b1;
      data_q  <= mux_d;
    end else if (i_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign o_a_ready = a_rdy;
  assign o_b_ready = b_rdy;
  assign o_sel_a   = sel_a_q;
  assign o_valid   = valid_q;
  assign o_data    = data_q;

endmodule

// File: tb/tb_scale_mux_arbiter.sv
// tb_scale_mux_arbiter: directed vector table, hand
// sequences and randomized run against a reference model.
module tb_scale_mux_arbiter;

  localparam int MAXB = 4;

  logic       clk;
  logic       rst;
  logic       av;
  logic [7:0] ad;
  logic       bv;
  logic [7:0] bd;
  logic       rdy;
  logic       a_ready;
  logic       b_ready;
  logic       sel_a;
  logic       o_valid;
  logic [7:0] o_data;

  int errors = 0;
  int checks = 0;

  scale_mux_arbiter #(
    .WIDTH(8),
    .MAX_BURST(MAXB)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_a_valid(av),
    .i_a_data (ad),
    .o_a_ready(a_ready),
    .i_b_valid(bv),
    .i_b_data (bd),
    .o_b_ready(b_ready),
    .o_sel_a  (sel_a),
    .o_valid  (o_valid),
    .o_data   (o_data),
    .i_ready  (rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         chk;
    bit         rst;
    bit         av;
    logic [7:0] ad;
    bit         bv;
    logic [7:0] bd;
    bit         rdy;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [11:0] outs();
    return {o_valid, o_data, sel_a, a_ready, b_ready};
  endfunction

  task automatic chk(string nm, logic [11:0] got,
                     logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got v/d/sel/ar/br=%b/%h/%b/%b/%b exp %b/%h/%b/%b/%b",
               nm, got[11], got[10:3], got[2], got[1],
               got[0], exp[11], exp[10:3], exp[2],
               exp[1], exp[0]);
    end
  endtask

  task automatic drive(bit r, bit a_v, logic [7:0] a_d,
                       bit b_v, logic [7:0] b_d,
                       bit c_r);
    @(negedge clk);
    rst = r;
    av  = a_v;
    ad  = a_d;
    bv  = b_v;
    bd  = b_d;
    rdy = c_r;
    #1;
  endtask

  task automatic step(string nm, bit r, bit a_v,
                      logic [7:0] a_d, bit b_v,
                      logic [7:0] b_d, bit c_r,
                      logic [11:0] exp);
    drive(r, a_v, a_d, b_v, b_d, c_r);
    chk(nm, outs(), exp);
  endtask

  task automatic add(bit c, bit r, bit a_v,
                     logic [7:0] a_d, bit b_v,
                     logic [7:0] b_d, bit c_r,
                     logic [11:0] e);
    vec_t v;
    v.chk = c; v.rst = r;
    v.av = a_v; v.ad = a_d;
    v.bv = b_v; v.bd = b_d;
    v.rdy = c_r; v.exp = e;
    vecs.push_back(v);
  endtask

  function automatic logic [11:0] ex(bit v, logic [7:0] d,
                                     bit s, bit ar, bit br);
    return {v, d, s, ar, br};
  endfunction

  // Reference model: owner index (-1 idle, 0 A, 1 B),
  // streak of words granted to the current owner.
  int         m_own;
  int         m_last;
  int         m_streak;
  bit         m_v;
  logic [7:0] m_d;

  function automatic bit m_rdy(int x, bit c_r);
    return (m_own == x) && (!m_v || c_r);
  endfunction

  function automatic logic [11:0] m_outs(bit c_r);
    return {m_v, m_d, m_own == 0, m_rdy(0, c_r),
            m_rdy(1, c_r)};
  endfunction

  task automatic m_step(bit r, bit v0, logic [7:0] d0,
                        bit v1, logic [7:0] d1,
                        bit c_r);
    bit         v[2];
    logic [7:0] d[2];
    int         x;
    int         o;
    v[0] = v0; v[1] = v1;
    d[0] = d0; d[1] = d1;
    if (r) begin
      m_own = -1; m_last = 1; m_streak = 0;
      m_v = 0; m_d = 8'h00;
      return;
    end
    x = -1;
    for (int i = 0; i < 2; i++)
      if (v[i] && m_rdy(i, c_r)) x = i;
    if (x >= 0) begin
      m_d = d[x]; m_v = 1; m_last = x;
    end else if (m_v && c_r) begin
      m_v = 0;
    end
    if (m_own < 0) begin
      m_streak = 0;
      if (v[0] && v[1]) m_own = 1 - m_last;
      else if (v[0]) m_own = 0;
      else if (v[1]) m_own = 1;
    end else begin
      o = 1 - m_own;
      if (x == m_own && m_streak + 1 >= MAXB && v[o]) begin
        m_own = o; m_streak = 0;
      end else if (!v[m_own]) begin
        m_own = v[o] ? o : -1;
        m_streak = 0;
      end else if (x == m_own) begin
        m_streak++;
      end
    end
  endtask

  initial begin
    logic [7:0] words[$];
    bit         qv[2];
    logic [7:0] qd[2];
    bit         r;
    bit         c_r;
    bit         acc[2];

    rst = 1'b1; av = 0; ad = 0;
    bv = 0; bd = 0; rdy = 0;

    // Directed table: reset, single A, tie from idle.
    add(0, 1, 1, 8'h11, 1, 8'h22, 1, ex(0, 8'h00, 0, 0, 0));
    add(1, 1, 1, 8'h11, 1, 8'h22, 1, ex(0, 8'h00, 0, 0, 0));
    add(1, 0, 0, 8'h00, 0, 8'h00, 1, ex(0, 8'h00, 0, 0, 0));
    add(1, 0, 1, 8'hff, 0, 8'h00, 1, ex(0, 8'h00, 0, 0, 0));
    add(1, 0, 1, 8'hff, 0, 8'h00, 1, ex(0, 8'h00, 1, 1, 0));
    add(1, 0, 0, 8'h00, 0, 8'h00, 1, ex(1, 8'hff, 1, 1, 0));
    add(1, 0, 0, 8'h00, 0, 8'h00, 1, ex(0, 8'hff, 0, 0, 0));
    add(1, 1, 0, 8'h00, 0, 8'h00, 1, ex(0, 8'hff, 0, 0, 0));
    add(1, 0, 1, 8'h00, 1, 8'hff, 1, ex(0, 8'h00, 0, 0, 0));
    add(1, 0, 1, 8'h00, 1, 8'hff, 1, ex(0, 8'h00, 1, 1, 0));
    add(1, 0, 0, 8'h00, 1, 8'hff, 1, ex(1, 8'h00, 1, 1, 0));
    add(1, 0, 0, 8'h00, 1, 8'hff, 1, ex(0, 8'h00, 0, 0, 1));
    add(1, 0, 0, 8'h00, 0, 8'h00, 1, ex(1, 8'hff, 0, 0, 1));
    add(1, 0, 0, 8'h00, 0, 8'h00, 1, ex(0, 8'hff, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].av, vecs[i].ad,
            vecs[i].bv, vecs[i].bd, vecs[i].rdy);
      if (vecs[i].chk)
        chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Fairness: aa x4, 55 x4, aa x4.
    drive(1, 0, 8'h00, 0, 8'h00, 1);
    for (int c = 0; c < 20; c++) begin
      drive(0, 1, 8'haa, 1, 8'h55, 1);
      if (o_valid) words.push_back(o_data);
    end
    checks++;
    if (words.size() < 12) begin
      errors++;
      $display("FAIL fair_count got=%0d exp>=12",
               words.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        logic [7:0] e;
        e = ((i / 4) % 2 == 0) ? 8'haa : 8'h55;
        chk($sformatf("fair%0d", i),
            {1'b1, words[i], 3'b000},
            {1'b1, e, 3'b000});
      end
    end

    // Backpressure holds the word, then releases.
    drive(1, 0, 8'h00, 0, 8'h00, 1);
    step("bp0", 0, 1, 8'h01, 0, 8'h00, 1, ex(0, 8'h00, 0, 0, 0));
    step("bp1", 0, 1, 8'h01, 0, 8'h00, 1, ex(0, 8'h00, 1, 1, 0));
    for (int c = 0; c < 3; c++)
      step("bp_hold", 0, 1, 8'h02, 0, 8'h00, 0,
           ex(1, 8'h01, 1, 0, 0));
    step("bp_rel", 0, 1, 8'h02, 0, 8'h00, 1, ex(1, 8'h01, 1, 1, 0));
    step("bp_next", 0, 0, 8'h00, 0, 8'h00, 1, ex(1, 8'h02, 1, 1, 0));
    step("bp_empty", 0, 0, 8'h00, 0, 8'h00, 1, ex(0, 8'h02, 0, 0, 0));

    // Reset mid-burst: A wins again afterwards.
    drive(1, 0, 8'h00, 0, 8'h00, 1);
    step("mr0", 0, 1, 8'haa, 1, 8'h55, 1, ex(0, 8'h00, 0, 0, 0));
    step("mr1", 0, 1, 8'haa, 1, 8'h55, 1, ex(0, 8'h00, 1, 1, 0));
    step("mr2", 0, 1, 8'haa, 1, 8'h55, 1, ex(1, 8'haa, 1, 1, 0));
    step("mr_rst", 1, 1, 8'haa, 1, 8'h55, 1, ex(1, 8'haa, 1, 1, 0));
    step("mr_idle", 0, 1, 8'haa, 1, 8'h55, 1, ex(0, 8'h00, 0, 0, 0));
    step("mr_gnt", 0, 1, 8'haa, 1, 8'h55, 1, ex(0, 8'h00, 1, 1, 0));

    // Randomized run against the model.
    drive(1, 0, 8'h00, 0, 8'h00, 1);
    m_step(1, 0, 8'h00, 0, 8'h00, 1);
    qv[0] = 0; qv[1] = 0;
    qd[0] = 0; qd[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int x = 0; x < 2; x++)
        if (!qv[x] && $urandom_range(0, 99) < 60) begin
          qv[x] = 1;
          qd[x] = 8'($urandom);
        end
      r   = ($urandom_range(0, 99) < 2);
      c_r = ($urandom_range(0, 99) < 70);
      drive(r, qv[0], qd[0], qv[1], qd[1], c_r);
      chk("rand", outs(), m_outs(c_r));
      for (int x = 0; x < 2; x++)
        acc[x] = !r && qv[x] && m_rdy(x, c_r);
      m_step(r, qv[0], qd[0], qv[1], qd[1], c_r);
      for (int x = 0; x < 2; x++)
        if (acc[x]) qv[x] = 0;
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
